// File: rtl/dcache_refill_if.sv
// Single-beat read bus between the refill engine and memory.
// Master issues the request; slave returns one data beat.
interface dcache_refill_if #(
    parameter int ADDR_W = 64
) ();
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_ready;
    logic              bus_rvalid;
    logic [63:0]       bus_rdata;
    logic              bus_err;

    modport master (
        output bus_req,
        output bus_addr,
        input  bus_ready,
        input  bus_rvalid,
        input  bus_rdata,
        input  bus_err
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        output bus_ready,
        output bus_rvalid,
        output bus_rdata,
        output bus_err
    );
endinterface

// File: rtl/dcache_refill.sv
// Load-miss refill engine: fetches the aligned doubleword and fills the cache.
// Optional WAIT timeout is built when DCACHE_REFILL_TIMEOUT_EN is defined.
module dcache_refill #(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              invalid,
    input  logic              miss,
    input  logic [ADDR_W-1:0] addr,
    output logic              stall,
    dcache_refill_if.master   bus,
    output logic              update,
    output logic [63:0]       update_data,
    output logic              fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FILL,
        DRAIN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       data_q;
    logic              take_miss;
    logic              take_data;

    if (TIMEOUT >= (1 << CNT_W)) begin : g_cfg_bad
        $error("TIMEOUT does not fit in CNT_W bits");
    end

`ifdef DCACHE_REFILL_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             expired;

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    assign take_miss = (state_q == IDLE) & miss & ~invalid;
    assign take_data = (state_q == WAIT) & bus.bus_rvalid
                     & ~bus.bus_err & ~invalid;

    always_comb begin
        state_d     = state_q;
        stall       = miss | (state_q != IDLE);
        bus.bus_req = 1'b0;
        update      = 1'b0;
        fault       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (take_miss) state_d = REQ;
            end
            REQ: begin
                bus.bus_req = 1'b1;
                if (invalid)            state_d = IDLE;
                else if (bus.bus_ready) state_d = WAIT;
            end
            WAIT: begin
                // A flush without the beat must still absorb it later
                if (invalid) begin
                    state_d = bus.bus_rvalid ? IDLE : DRAIN;
                end else if (bus.bus_rvalid) begin
                    fault   = bus.bus_err;
                    state_d = bus.bus_err ? IDLE : FILL;
`ifdef DCACHE_REFILL_TIMEOUT_EN
                end else if (expired) begin
                    fault   = 1'b1;
                    state_d = DRAIN;
`endif
                end
            end
            FILL: begin
                update  = ~invalid;
                state_d = IDLE;
            end
            DRAIN: begin
                if (bus.bus_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.bus_addr = addr_q;
    assign update_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take_miss) addr_q <= addr & ~ADDR_W'(7);
            if (take_data) data_q <= bus.bus_rdata;
        end
    end

`ifdef DCACHE_REFILL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == REQ) begin
            cnt_q <= '0;
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_refill.sv
// Randomized transaction-level bench for dcache_refill.
// Expected waveforms are derived from per-transaction cycle arithmetic.
module tb_dcache_refill;

`ifdef DCACHE_REFILL_TIMEOUT_EN
    localparam int TO = 4;
    localparam int NKIND = 8;
`else
    localparam int TO = 255;
    localparam int NKIND = 7;
`endif

    localparam int K_OK       = 0;
    localparam int K_ERR      = 1;
    localparam int K_INV_REQ  = 2;
    localparam int K_DRAIN    = 3;
    localparam int K_INV_RV   = 4;
    localparam int K_INV_FILL = 5;
    localparam int K_INV_MISS = 6;
    localparam int K_TIMEOUT  = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        invalid;
    logic        miss;
    logic [63:0] addr;
    logic        stall;
    logic        update;
    logic [63:0] update_data;
    logic        fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dcache_refill_if #(.ADDR_W(64)) bus_if ();

    dcache_refill #(
        .ADDR_W (64),
        .TIMEOUT(TO),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .invalid    (invalid),
        .miss       (miss),
        .addr       (addr),
        .stall      (stall),
        .bus        (bus_if),
        .update     (update),
        .update_data(update_data),
        .fault      (fault)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // t=0 is the miss cycle; all event times are relative to it
    task automatic run_txn(input int kind, input int rw, input int vw,
                           input logic [63:0] a, input logic [63:0] d);
        int acc, wst, rv, inv_t, flt_t, upd_t, end_t, req_end, len;
        logic err_rv;
        logic e_stall, e_req, e_upd, e_flt;
        acc     = 1 + rw;
        wst     = acc + 1;
        rv      = wst + vw;
        inv_t   = -1;
        flt_t   = -1;
        upd_t   = -1;
        err_rv  = 1'b0;
        req_end = acc;
        end_t   = rv;
        case (kind)
            K_OK: begin
                upd_t = rv + 1;
                end_t = rv + 1;
            end
            K_ERR: begin
                err_rv = 1'b1;
                flt_t  = rv;
            end
            K_INV_REQ: begin
                inv_t   = $urandom_range(1, acc);
                req_end = inv_t;
                end_t   = inv_t;
                acc     = -1;
                rv      = -1;
            end
            K_DRAIN: begin
                inv_t  = wst + $urandom_range(0, 2);
                rv     = inv_t + $urandom_range(1, 3);
                err_rv = 1'($urandom % 2);
                end_t  = rv;
            end
            K_INV_RV: begin
                inv_t = rv;
            end
            K_INV_FILL: begin
                inv_t = rv + 1;
                end_t = rv + 1;
            end
            K_INV_MISS: begin
                inv_t   = 0;
                req_end = 0;
                end_t   = 0;
                acc     = -1;
                rv      = -1;
            end
            default: begin
                flt_t  = wst + TO - 1;
                rv     = flt_t + $urandom_range(1, 3);
                err_rv = 1'($urandom % 2);
                end_t  = rv;
            end
        endcase
        len = end_t + 3;
        for (int t = 0; t < len; t++) begin
            e_stall = (t <= end_t);
            e_req   = (t >= 1) && (t <= req_end);
            e_upd   = (t == upd_t);
            e_flt   = (t == flt_t);
            miss    = (t == 0) || (e_stall && t > 0 && ($urandom % 2 == 1));
            addr    = a;
            invalid = (t == inv_t);
            bus_if.bus_ready  = (t == acc);
            bus_if.bus_rvalid = (t == rv) ||
                (((t >= 1 && t <= req_end) || t > end_t) &&
                 ($urandom % 4 == 0));
            bus_if.bus_err    = (t == rv) ? err_rv : 1'($urandom % 2);
            bus_if.bus_rdata  = (t == rv) ? d : rnd64();
            @(negedge clk);
            chk("stall", 64'(stall), 64'(e_stall));
            chk("bus_req", 64'(bus_if.bus_req), 64'(e_req));
            chk("update", 64'(update), 64'(e_upd));
            chk("fault", 64'(fault), 64'(e_flt));
            if (e_req) chk("bus_addr", bus_if.bus_addr, {a[63:3], 3'b000});
            if (e_upd) chk("update_data", update_data, d);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_rst(input logic [63:0] a);
        miss              = 1'b1;
        addr              = a;
        invalid           = 1'b0;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_err    = 1'b0;
        @(negedge clk);
        chk("rst_miss_stall", 64'(stall), 64'd1);
        @(posedge clk);
        #1;
        miss = 1'b0;
        @(negedge clk);
        chk("rst_req", 64'(bus_if.bus_req), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_stall", 64'(stall), 64'd0);
        chk("rst_async_req", 64'(bus_if.bus_req), 64'd0);
        chk("rst_async_addr", bus_if.bus_addr, 64'd0);
        chk("rst_async_upd", 64'(update), 64'd0);
        chk("rst_async_flt", 64'(fault), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_err    = 1'($urandom % 2);
            bus_if.bus_rdata  = rnd64();
            @(negedge clk);
            chk("rst_after_stall", 64'(stall), 64'd0);
            chk("rst_after_req", 64'(bus_if.bus_req), 64'd0);
            chk("rst_after_upd", 64'(update), 64'd0);
            chk("rst_after_flt", 64'(fault), 64'd0);
            @(posedge clk);
            #1;
        end
        bus_if.bus_rvalid = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        invalid           = 1'b0;
        miss              = 1'b0;
        addr              = '0;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
        bus_if.bus_err    = 1'b0;
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_req", 64'(bus_if.bus_req), 64'd0);
        chk("reset_addr", bus_if.bus_addr, 64'd0);
        chk("reset_upd", 64'(update), 64'd0);
        chk("reset_data", update_data, 64'd0);
        chk("reset_flt", 64'(fault), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_txn(K_OK, 0, 0, 64'h8000_1234,
                64'hDEAD_BEEF_0123_4567);
        run_txn(K_OK, 5, 0, rnd64(), rnd64());
        run_txn(K_ERR, 0, 1, rnd64(), rnd64());
        run_txn(K_DRAIN, 1, 0, rnd64(), rnd64());
        run_rst(rnd64());
`ifdef DCACHE_REFILL_TIMEOUT_EN
        run_txn(K_TIMEOUT, 0, 0, rnd64(), rnd64());
`endif
        for (int k = 0; k < NKIND; k++) begin
            run_txn(k, $urandom_range(0, 5), $urandom_range(0, 3),
                    rnd64(), rnd64());
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 25 == 0) begin
                run_rst(rnd64());
            end else begin
                run_txn(int'($urandom_range(0, NKIND - 1)),
                        $urandom_range(0, 5), $urandom_range(0, 3),
                        rnd64(), rnd64());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
